modem_axil_master: RTL and testbench

AXI4-Lite initiator that drives the modem control/status register slave from a simple command port. It sits between a configuration sequencer (soft core, UART bridge or boot ROM walker) and the modem's 8-bit-address, 32-bit-data register interface. It issues one single-beat write or read per command, returns the response, and keeps transaction, error and timeout statistics.

---
 rtl/modem_axil_master_if.sv | 58 +++++
 rtl/modem_axil_master.sv | 232 +++++++++++++++++++++++
 tb/tb_modem_axil_master.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modem_axil_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : modem_axil_master_if
//  Purpose  : AXI4-Lite channel bundle between the modem register initiator
//             and the modem control/status register slave.
//  Revision : 1.0 - initial release
// ============================================================================
interface modem_axil_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]              M_AXI_AWPROT;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]              M_AXI_ARPROT;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface
`default_nettype wire

// File: rtl/modem_axil_master.sv
`default_nettype none
// ============================================================================
//  Module   : modem_axil_master
//  Purpose  : Command-port to AXI4-Lite initiator for the modem register map,
//             one single-beat access per command, with usage statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module modem_axil_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYC        = 256
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_wr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
    output logic                          rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_timeout,
    output logic [15:0]                   wr_cnt,
    output logic [15:0]                   rd_cnt,
    output logic [15:0]                   err_cnt,
    modem_axil_master_if.master           m_axi
);

    localparam logic [15:0]                     c_timeout = 16'(TIMEOUT_CYC);
    localparam logic [2:0]                      c_prot    = 3'b000;
    localparam logic [C_M_AXI_DATA_WIDTH/8-1:0] c_wstrb   = '1;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WR_ADDR_DATA = 3'd1,
        S_WR_RESP      = 3'd2,
        S_RD_ADDR      = 3'd3,
        S_RD_DATA      = 3'd4,
        S_RESP         = 3'd5
    } state_t;

    state_t                          r_state;
    logic                            r_rst_done;
    logic                            r_cmd_ready;
    logic                            r_wr;
    logic                            r_aw_done;
    logic                            r_w_done;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_araddr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
    logic                            r_awvalid;
    logic                            r_wvalid;
    logic                            r_bready;
    logic                            r_arvalid;
    logic                            r_rready;
    logic                            r_rsp_valid;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]                      r_rsp_resp;
    logic                            r_timeout;
    logic [15:0]                     r_to_cnt;
    logic [15:0]                     r_wr_cnt;
    logic [15:0]                     r_rd_cnt;
    logic [15:0]                     r_err_cnt;

    logic                            w_aw_hs;
    logic                            w_w_hs;
    logic                            w_aw_done;
    logic                            w_w_done;
    logic                            w_busy;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   w_addr_aligned;

    assign w_aw_hs        = r_awvalid && m_axi.M_AXI_AWREADY;
    assign w_w_hs         = r_wvalid  && m_axi.M_AXI_WREADY;
    assign w_aw_done      = r_aw_done || w_aw_hs;
    assign w_w_done       = r_w_done  || w_w_hs;
    assign w_busy         = (r_state != S_IDLE) && (r_state != S_RESP);
    assign w_addr_aligned = {cmd_addr[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state     <= S_IDLE;
            r_rst_done  <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_wr        <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_timeout   <= 1'b0;
            r_to_cnt    <= 16'd0;
            r_wr_cnt    <= 16'd0;
            r_rd_cnt    <= 16'd0;
            r_err_cnt   <= 16'd0;
        end else begin
            r_rst_done  <= 1'b1;
            r_rsp_valid <= 1'b0;

            // Timeout only flags a slow slave; the handshake is still awaited.
            if (w_busy && (r_to_cnt != 16'hFFFF)) begin
                r_to_cnt <= r_to_cnt + 16'd1;
                if (r_to_cnt + 16'd1 == c_timeout) begin
                    r_timeout <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_to_cnt    <= 16'd0;
                        r_wr        <= cmd_wr;
                        if (cmd_wr) begin
                            r_awaddr  <= w_addr_aligned;
                            r_wdata   <= cmd_wdata;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= S_WR_ADDR_DATA;
                        end else begin
                            r_araddr  <= w_addr_aligned;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_ADDR;
                        end
                    end else begin
                        // Held low for one cycle after reset release.
                        r_cmd_ready <= r_rst_done;
                    end
                end

                S_WR_ADDR_DATA: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                    end
                    r_aw_done <= w_aw_done;
                    r_w_done  <= w_w_done;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end

                S_WR_RESP: begin
                    if (m_axi.M_AXI_BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= m_axi.M_AXI_BRESP;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end

                S_RD_ADDR: begin
                    if (m_axi.M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end

                S_RD_DATA: begin
                    if (m_axi.M_AXI_RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= m_axi.M_AXI_RDATA;
                        r_rsp_resp  <= m_axi.M_AXI_RRESP;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end

                S_RESP: begin
                    // Statistics land here so they appear the cycle after rsp_valid.
                    if (r_wr) begin
                        r_wr_cnt <= sat_inc(r_wr_cnt);
                    end else begin
                        r_rd_cnt <= sat_inc(r_rd_cnt);
                    end
                    if (r_rsp_resp != 2'b00) begin
                        r_err_cnt <= sat_inc(r_err_cnt);
                    end
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_timeout = r_timeout;
    assign wr_cnt      = r_wr_cnt;
    assign rd_cnt      = r_rd_cnt;
    assign err_cnt     = r_err_cnt;

    assign m_axi.M_AXI_AWADDR  = r_awaddr;
    assign m_axi.M_AXI_AWPROT  = c_prot;
    assign m_axi.M_AXI_AWVALID = r_awvalid;
    assign m_axi.M_AXI_WDATA   = r_wdata;
    assign m_axi.M_AXI_WSTRB   = c_wstrb;
    assign m_axi.M_AXI_WVALID  = r_wvalid;
    assign m_axi.M_AXI_BREADY  = r_bready;
    assign m_axi.M_AXI_ARADDR  = r_araddr;
    assign m_axi.M_AXI_ARPROT  = c_prot;
    assign m_axi.M_AXI_ARVALID = r_arvalid;
    assign m_axi.M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_modem_axil_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_modem_axil_master
//  Purpose  : Directed bench for modem_axil_master with a delay-programmable
//             AXI4-Lite slave and a queue-based response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_modem_axil_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
    logic [15:0] err_cnt;

    modem_axil_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) axi ();

    modem_axil_master #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (8),
        .TIMEOUT_CYC        (8)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_wr        (cmd_wr),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .wr_cnt        (wr_cnt),
        .rd_cnt        (rd_cnt),
        .err_cnt       (err_cnt),
        .m_axi         (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic [31:0] s_rdata = 32'h0;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit          aw_got, w_got, ar_got;
    int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [7:0]  s_awaddr, s_araddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;

    assign axi.M_AXI_AWREADY = axi.M_AXI_AWVALID && (aw_cnt >= aw_dly);
    assign axi.M_AXI_WREADY  = axi.M_AXI_WVALID  && (w_cnt  >= w_dly);
    assign axi.M_AXI_ARREADY = axi.M_AXI_ARVALID && (ar_cnt >= ar_dly);
    assign axi.M_AXI_BVALID  = aw_got && w_got && (b_cnt >= b_dly);
    assign axi.M_AXI_BRESP   = s_bresp;
    assign axi.M_AXI_RVALID  = ar_got && (r_cnt >= r_dly);
    assign axi.M_AXI_RDATA   = s_rdata;
    assign axi.M_AXI_RRESP   = s_rresp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 0; w_got <= 0; ar_got <= 0;
        end else begin
            aw_cnt <= (axi.M_AXI_AWVALID && !axi.M_AXI_AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi.M_AXI_WVALID  && !axi.M_AXI_WREADY)  ? w_cnt + 1  : 0;
            ar_cnt <= (axi.M_AXI_ARVALID && !axi.M_AXI_ARREADY) ? ar_cnt + 1 : 0;
            if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin
                aw_got <= 1; aw_hs <= aw_hs + 1; s_awaddr <= axi.M_AXI_AWADDR;
            end
            if (axi.M_AXI_WVALID && axi.M_AXI_WREADY) begin
                w_got <= 1; w_hs <= w_hs + 1; s_wdata <= axi.M_AXI_WDATA; s_wstrb <= axi.M_AXI_WSTRB;
            end
            if (aw_got && w_got && !(axi.M_AXI_BVALID && axi.M_AXI_BREADY)) b_cnt <= b_cnt + 1;
            if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) begin
                aw_got <= 0; w_got <= 0; b_cnt <= 0; b_hs <= b_hs + 1;
            end
            if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
                ar_got <= 1; ar_hs <= ar_hs + 1; s_araddr <= axi.M_AXI_ARADDR;
            end
            if (ar_got && !(axi.M_AXI_RVALID && axi.M_AXI_RREADY)) r_cnt <= r_cnt + 1;
            if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) begin
                ar_got <= 0; r_cnt <= 0; r_hs <= r_hs + 1;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
        logic [15:0] wr, rd, err;
    } exp_t;

    exp_t sbq[$];
    exp_t e_cur;
    bit   cnt_pend;
    int   rsp_seen;

    initial begin
        cnt_pend = 0;
        rsp_seen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt_pend = 0;
            end else begin
                if (cnt_pend) begin
                    chk("wr_cnt", 32'(wr_cnt), 32'(e_cur.wr));
                    chk("rd_cnt", 32'(rd_cnt), 32'(e_cur.rd));
                    chk("err_cnt", 32'(err_cnt), 32'(e_cur.err));
                    cnt_pend = 0;
                    rsp_seen++;
                end
                if (rsp_valid) begin
                    if (sbq.size() == 0) begin
                        chk("rsp_unexpected", 32'd1, 32'd0);
                    end else begin
                        e_cur = sbq.pop_front();
                        chk("rsp_rdata", rsp_rdata, e_cur.rdata);
                        chk("rsp_resp", 32'(rsp_resp), 32'(e_cur.resp));
                        chk("rsp_timeout", 32'(rsp_timeout), 32'(e_cur.to));
                        cnt_pend = 1;
                    end
                end
            end
        end
    end

    // ---------------- valid hold / drop monitor ----------------
    initial begin
        logic       p_ok, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
        logic [7:0] p_awaddr, p_araddr;
        logic [31:0] p_wdata;
        p_ok = 0;
        forever begin
            @(negedge clk);
            if (rst_n && p_ok) begin
                if (p_awv && p_awr)  chk("aw_drop", 32'(axi.M_AXI_AWVALID), 32'd0);
                if (p_awv && !p_awr) begin
                    chk("aw_hold", 32'(axi.M_AXI_AWVALID), 32'd1);
                    chk("aw_stable", 32'(axi.M_AXI_AWADDR), 32'(p_awaddr));
                end
                if (p_wv && p_wr)    chk("w_drop", 32'(axi.M_AXI_WVALID), 32'd0);
                if (p_wv && !p_wr) begin
                    chk("w_hold", 32'(axi.M_AXI_WVALID), 32'd1);
                    chk("w_stable", axi.M_AXI_WDATA, p_wdata);
                end
                if (p_arv && p_arr)  chk("ar_drop", 32'(axi.M_AXI_ARVALID), 32'd0);
                if (p_arv && !p_arr) begin
                    chk("ar_hold", 32'(axi.M_AXI_ARVALID), 32'd1);
                    chk("ar_stable", 32'(axi.M_AXI_ARADDR), 32'(p_araddr));
                end
            end
            p_ok = rst_n;
            p_awv = axi.M_AXI_AWVALID; p_awr = axi.M_AXI_AWREADY; p_awaddr = axi.M_AXI_AWADDR;
            p_wv  = axi.M_AXI_WVALID;  p_wr  = axi.M_AXI_WREADY;  p_wdata  = axi.M_AXI_WDATA;
            p_arv = axi.M_AXI_ARVALID; p_arr = axi.M_AXI_ARREADY; p_araddr = axi.M_AXI_ARADDR;
        end
    end

    // ---------------- stimulus ----------------
    int exp_wr = 0, exp_rd = 0, exp_err = 0;
    int last_lat, last_low, last_to_first, last_bready9;
    int aw0, w0, b0, ar0;

    task automatic snap();
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_cmd(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_resp, input bit exp_to);
        exp_t e;
        int   n, seen0;
        wait_ready();
        if (wr) exp_wr++; else exp_rd++;
        if (exp_resp != 2'b00) exp_err++;
        e.rdata = exp_rdata; e.resp = exp_resp; e.to = exp_to;
        e.wr = 16'(exp_wr); e.rd = 16'(exp_rd); e.err = 16'(exp_err);
        sbq.push_back(e);
        snap();
        cmd_valid = 1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
        @(posedge clk);
        #1 cmd_valid = 0;
        seen0 = rsp_seen;
        n = 0; last_lat = -1; last_low = 0; last_to_first = -1; last_bready9 = -1;
        while (rsp_seen == seen0 && n < 200) begin
            @(negedge clk);
            n++;
            if (rsp_valid && last_lat < 0) last_lat = n;
            if (!cmd_ready) last_low++;
            if (rsp_timeout && last_to_first < 0) last_to_first = n;
            if (n == 9) last_bready9 = int'(axi.M_AXI_BREADY);
        end
        chk("rsp_wait", 32'(rsp_seen != seen0), 32'd1);
    endtask

    initial begin
        rst_n = 0; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        #22;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_awvalid", 32'(axi.M_AXI_AWVALID), 32'd0);
        chk("rst_wvalid", 32'(axi.M_AXI_WVALID), 32'd0);
        chk("rst_arvalid", 32'(axi.M_AXI_ARVALID), 32'd0);
        chk("rst_readies", 32'({axi.M_AXI_BREADY, axi.M_AXI_RREADY}), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'd0);
        chk("rst_cnts", 32'(wr_cnt | rd_cnt | err_cnt), 32'd0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1 chk("ready_edge1", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1 chk("ready_edge2", 32'(cmd_ready), 32'd1);

        // zero-wait write
        do_cmd(1, 8'h0C, 32'h0000_0005, 32'h0, 2'b00, 0);
        chk("wr_lat", 32'(last_lat), 32'd3);
        chk("wr_awaddr", 32'(s_awaddr), 32'h0C);
        chk("wr_wdata", s_wdata, 32'h5);
        chk("wr_wstrb", 32'(s_wstrb), 32'hF);
        chk("wr_prot", 32'({axi.M_AXI_AWPROT, axi.M_AXI_ARPROT}), 32'd0);
        chk("wr_one_b", 32'(b_hs - b0), 32'd1);

        // zero-wait read
        s_rdata = 32'h00AB_CDEF;
        do_cmd(0, 8'h14, 32'h0, 32'h00AB_CDEF, 2'b00, 0);
        chk("rd_lat", 32'(last_lat), 32'd3);
        chk("rd_ready_low", 32'(last_low), 32'd3);
        chk("rd_araddr", 32'(s_araddr), 32'h14);

        // W 4 cycles after AW; unaligned address is forced to word boundary
        aw_dly = 0; w_dly = 4;
        do_cmd(1, 8'h0F, 32'hA5A5_0001, 32'h0, 2'b00, 0);
        chk("wlate_lat", 32'(last_lat), 32'd7);
        chk("wlate_awaddr", 32'(s_awaddr), 32'h0C);
        chk("wlate_counts", 32'({8'(aw_hs - aw0), 8'(w_hs - w0), 8'(b_hs - b0)}), 32'h010101);

        // AW 4 cycles after W
        aw_dly = 4; w_dly = 0;
        do_cmd(1, 8'h20, 32'h0000_1234, 32'h0, 2'b00, 0);
        chk("awlate_lat", 32'(last_lat), 32'd7);
        chk("awlate_wdata", s_wdata, 32'h1234);
        chk("awlate_counts", 32'({8'(aw_hs - aw0), 8'(w_hs - w0), 8'(b_hs - b0)}), 32'h010101);

        // both accepted together after 2 waits
        aw_dly = 2; w_dly = 2;
        do_cmd(1, 8'h24, 32'h0000_00FF, 32'h0, 2'b00, 0);
        chk("both_lat", 32'(last_lat), 32'd5);
        chk("both_counts", 32'({8'(aw_hs - aw0), 8'(w_hs - w0), 8'(b_hs - b0)}), 32'h010101);
        aw_dly = 0; w_dly = 0;

        // SLVERR read
        s_rdata = 32'hDEAD_0001; s_rresp = 2'b10;
        do_cmd(0, 8'h17, 32'h0, 32'hDEAD_0001, 2'b10, 0);
        chk("err_araddr", 32'(s_araddr), 32'h14);
        chk("err_ar_one", 32'(ar_hs - ar0), 32'd1);
        s_rresp = 2'b00;

        // BVALID withheld 20 cycles with an 8-cycle timeout
        b_dly = 20;
        do_cmd(1, 8'h30, 32'h0000_0077, 32'h0, 2'b00, 1);
        chk("to_first", 32'(last_to_first), 32'd9);
        chk("to_bready_held", 32'(last_bready9), 32'd1);
        chk("to_lat", 32'(last_lat), 32'd23);
        chk("to_sticky", 32'(rsp_timeout), 32'd1);
        b_dly = 0;

        s_rdata = 32'h0000_0011;
        do_cmd(0, 8'h00, 32'h0, 32'h0000_0011, 2'b00, 0);
        chk("to_cleared", 32'(last_to_first), 32'hFFFF_FFFF);

        // reset during RD_DATA
        r_dly = 50;
        wait_ready();
        cmd_valid = 1; cmd_wr = 0; cmd_addr = 8'h08;
        @(posedge clk);
        #1 cmd_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rready", 32'(axi.M_AXI_RREADY), 32'd1);
        rst_n = 0;
        #1;
        chk("mid_rst_rready", 32'(axi.M_AXI_RREADY), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_cnts", 32'({wr_cnt, rd_cnt} | 32'(err_cnt)), 32'd0);
        exp_wr = 0; exp_rd = 0; exp_err = 0;
        r_dly = 0;
        @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1 chk("rel_edge1", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1 chk("rel_edge2", 32'(cmd_ready), 32'd1);

        s_rdata = 32'h0000_0055;
        do_cmd(0, 8'h04, 32'h0, 32'h0000_0055, 2'b00, 0);
        chk("post_rst_lat", 32'(last_lat), 32'd3);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
